x_startup_sequencer: RTL



---
 rtl/x_startup_sequencer.sv | 263 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/x_startup_sequencer.sv
// ============================================================================
// x_startup_sequencer
// ----------------------------------------------------------------------------
// Drives the device startup interface from the configuration side. Once
// configuration is complete (START) the block steps through startup phases
// 1..7. At the configured phases it releases GTS and GSR and asserts DONE.
// At phase 7 it flags end-of-startup (EOS) and waits in RUN.
//
// A program request (PROGREQ_IN) in RUN raises PREQ toward the user. The
// block then waits for the user acknowledge (PACK), bounded by PACK_TIMEOUT
// cycles. It then walks a three-edge shutdown that re-asserts GTS and GSR,
// drops DONE and returns to IDLE.
//
// Optional build macro:
//   STARTUP_SEQ_DONE_WAIT_EN  - when defined, the startup count stalls at
//                               DONE_CYCLE until the external DONE pad
//                               sense (DONE_IN) reads high, delaying every
//                               later phase. When undefined, DONE_IN is
//                               ignored and startup is purely count-driven.
//
// Parameters:
//   GTS_CYCLE     startup phase (1..6) at which GTS deasserts
//   GSR_CYCLE     startup phase (1..6) at which GSR deasserts
//   DONE_CYCLE    startup phase (1..6) at which DONE asserts
//   PACK_TIMEOUT  cycles in PREQ_WAIT before forced shutdown (1..65535)
//
// Ports:
//   CLK         in   sequencer clock, rising edge
//   RSTB        in   asynchronous active-low reset
//   START       in   configuration complete, level-sampled in IDLE
//   PROGREQ_IN  in   program request from configuration logic
//   PACK        in   user acknowledge of PREQ
//   DONE_IN     in   external DONE pad sense (optional feature only)
//   GSR         out  global set/reset, active high
//   GTS         out  global tristate, active high
//   DONE        out  internal DONE
//   EOS         out  end of startup
//   PREQ        out  program request to user
//   TIMEOUT     out  sticky flag: PACK never arrived
//   PHASE       out  current startup phase 0..7
//
// All outputs are registered; there is no combinational input-to-output path.
// ============================================================================
module x_startup_sequencer #(
    parameter int unsigned GTS_CYCLE    = 5,
    parameter int unsigned GSR_CYCLE    = 6,
    parameter int unsigned DONE_CYCLE   = 4,
    parameter int unsigned PACK_TIMEOUT = 256
) (
    input  logic       CLK,
    input  logic       RSTB,
    input  logic       START,
    input  logic       PROGREQ_IN,
    input  logic       PACK,
    input  logic       DONE_IN,
    output logic       GSR,
    output logic       GTS,
    output logic       DONE,
    output logic       EOS,
    output logic       PREQ,
    output logic       TIMEOUT,
    output logic [2:0] PHASE
);

    localparam int unsigned PHASE_W = 3;
    localparam int unsigned TMO_W   = 16;
    localparam int unsigned SD_W    = 2;

    localparam logic [PHASE_W-1:0] PH_GTS  = PHASE_W'(GTS_CYCLE);
    localparam logic [PHASE_W-1:0] PH_GSR  = PHASE_W'(GSR_CYCLE);
    localparam logic [PHASE_W-1:0] PH_DONE = PHASE_W'(DONE_CYCLE);
    localparam logic [PHASE_W-1:0] PH_LAST = PHASE_W'(7);

    // Counter value on the edge before the one that reaches PACK_TIMEOUT.
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(PACK_TIMEOUT - 1);

    localparam logic [SD_W-1:0]    SD_GTS  = SD_W'(0);
    localparam logic [SD_W-1:0]    SD_GSR  = SD_W'(1);

    // Elaboration-time parameter range check: a bad configuration stops the
    // build before time advances.
    if (GTS_CYCLE == 0 || GTS_CYCLE > 6 ||
        GSR_CYCLE == 0 || GSR_CYCLE > 6 ||
        DONE_CYCLE == 0 || DONE_CYCLE > 6 ||
        PACK_TIMEOUT == 0 || PACK_TIMEOUT > 65535) begin : g_param_err
        $fatal(1, "x_startup_sequencer: parameter out of range (GTS_CYCLE=%0d GSR_CYCLE=%0d DONE_CYCLE=%0d PACK_TIMEOUT=%0d)",
               GTS_CYCLE, GSR_CYCLE, DONE_CYCLE, PACK_TIMEOUT);
    end

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STARTUP   = 3'd1,
        S_RUN       = 3'd2,
        S_PREQ_WAIT = 3'd3,
        S_SHUTDOWN  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [TMO_W-1:0]     cnt_q,   cnt_d;
    logic [SD_W-1:0]      sd_q,    sd_d;
    logic                 gsr_q,   gsr_d;
    logic                 gts_q,   gts_d;
    logic                 done_q,  done_d;
    logic                 eos_q,   eos_d;
    logic                 preq_q,  preq_d;
    logic                 tmo_q,   tmo_d;

    // High on any edge that moves PHASE onto a new startup phase; gates
    // the per-phase GTS/GSR/DONE events.
    logic                 enter_phase;
    // High while the startup count must hold at the DONE phase.
    logic                 phase_hold;

`ifndef STARTUP_SEQ_DONE_WAIT_EN
    // Pad sense has no function in the purely count-driven build.
    logic                 unused_done_in;
    assign unused_done_in = DONE_IN;
`endif

    // State and output registers.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            cnt_q   <= '0;
            sd_q    <= '0;
            gsr_q   <= 1'b1;
            gts_q   <= 1'b1;
            done_q  <= 1'b0;
            eos_q   <= 1'b0;
            preq_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            sd_q    <= sd_d;
            gsr_q   <= gsr_d;
            gts_q   <= gts_d;
            done_q  <= done_d;
            eos_q   <= eos_d;
            preq_q  <= preq_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        sd_d        = sd_q;
        gsr_d       = gsr_q;
        gts_d       = gts_q;
        done_d      = done_q;
        eos_d       = eos_q;
        preq_d      = preq_q;
        tmo_d       = tmo_q;
        enter_phase = 1'b0;
        phase_hold  = 1'b0;

`ifdef STARTUP_SEQ_DONE_WAIT_EN
        phase_hold  = (phase_q == PH_DONE) && !DONE_IN;
`endif

        case (state_q)
            S_IDLE: begin
                // PROGREQ_IN and PACK have no effect before startup.
                if (START) begin
                    state_d     = S_STARTUP;
                    phase_d     = PHASE_W'(1);
                    tmo_d       = 1'b0;
                    enter_phase = 1'b1;
                end
            end

            S_STARTUP: begin
                // Program requests are neither acted on nor remembered here.
                if (!phase_hold) begin
                    phase_d     = phase_q + PHASE_W'(1);
                    enter_phase = 1'b1;
                    if (phase_d == PH_LAST) begin
                        eos_d   = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (PROGREQ_IN) begin
                    preq_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_PREQ_WAIT;
                end
            end

            S_PREQ_WAIT: begin
                // An acknowledge beats a timeout landing on the same edge.
                if (PACK) begin
                    preq_d  = 1'b0;
                    sd_d    = SD_GTS;
                    state_d = S_SHUTDOWN;
                end else if (cnt_q == TMO_LAST) begin
                    cnt_d   = cnt_q + TMO_W'(1);
                    tmo_d   = 1'b1;
                    preq_d  = 1'b0;
                    sd_d    = SD_GTS;
                    state_d = S_SHUTDOWN;
                end else begin
                    cnt_d   = cnt_q + TMO_W'(1);
                end
            end

            S_SHUTDOWN: begin
                // Tristate first, then reset, then drop DONE and go idle.
                case (sd_q)
                    SD_GTS: begin
                        eos_d = 1'b0;
                        gts_d = 1'b1;
                        sd_d  = SD_GSR;
                    end
                    SD_GSR: begin
                        gsr_d = 1'b1;
                        sd_d  = SD_W'(2);
                    end
                    default: begin
                        done_d  = 1'b0;
                        phase_d = '0;
                        sd_d    = '0;
                        state_d = S_IDLE;
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Each release/assert lands on the edge at which PHASE takes its value.
        if (enter_phase) begin
            if (phase_d == PH_GTS) begin
                gts_d = 1'b0;
            end
            if (phase_d == PH_GSR) begin
                gsr_d = 1'b0;
            end
            if (phase_d == PH_DONE) begin
                done_d = 1'b1;
            end
        end
    end

    assign GSR     = gsr_q;
    assign GTS     = gts_q;
    assign DONE    = done_q;
    assign EOS     = eos_q;
    assign PREQ    = preq_q;
    assign TIMEOUT = tmo_q;
    assign PHASE   = phase_q;

endmodule
